// File: rtl/params_loader.sv
// params_loader
//
// Streams parameter words from the host side into the parameters memory.
// A command latches a start address, a word count and a fixed-point format.
// After that the block accepts one word per valid/ready beat and issues one
// registered write per beat. Compute-side reads always take priority.
//
// State table:
//   state | meaning
//   IDLE  | waiting for a command; an illegal command pulses err
//   LOAD  | accepting words; one registered write per accepted beat
//   DONE  | last write issued; done pulses this cycle; back to IDLE next
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cmd_start/addr/len/format   command strobe and its arguments
//   in_valid/in_ready/in_data   word stream from the host
//   rd_busy             compute is reading the memory this cycle
//   wr_en/addr/data/format, wr_chip_en   parameters-memory write port
//   busy, done, err     status: busy in LOAD/DONE, done/err one-cycle pulses

module params_loader #(
    parameter int DATA_W      = 22,
    parameter int ADDR_W      = 15,
    parameter int TOTAL_WORDS = 31744,
    parameter int FMT_W       = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_start,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic [FMT_W-1:0]  cmd_format,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              rd_busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [FMT_W-1:0]  wr_format,
    output logic              wr_chip_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   TOTAL_L = (ADDR_W + 1)'(TOTAL_WORDS);
    localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [FMT_W-1:0]  fmt_q, fmt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [FMT_W-1:0]  wr_format_q, wr_format_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              wr_chip_en_q;

    logic [ADDR_W:0]   cmd_sum;
    logic              cmd_legal;
    logic              beat;

    // The length bound keeps the ADDR_W+1 bit sum from wrapping, so a huge
    // cmd_len cannot alias to a small in-range sum.
    assign cmd_sum   = {1'b0, cmd_addr} + cmd_len;
    assign cmd_legal = (cmd_len != '0) && (cmd_len <= TOTAL_L) && (cmd_sum <= TOTAL_L);

    // Reads win: the memory selects its address by write enable.
    assign in_ready  = (state_q == LOAD) && !rd_busy;
    assign beat      = in_ready && in_valid;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        fmt_d       = fmt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_format_d = wr_format_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    if (cmd_legal) begin
                        addr_d      = cmd_addr;
                        remaining_d = cmd_len;
                        fmt_d       = cmd_format;
                        state_d     = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (beat) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = addr_q;
                    wr_data_d   = in_data;
                    wr_format_d = fmt_q;
                    addr_d      = addr_q + ONE_A;
                    remaining_d = remaining_q - ONE_L;
                    // done lines up with the final write strobe.
                    if (remaining_q == ONE_L) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            fmt_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_format_q  <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            wr_chip_en_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            fmt_q        <= fmt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_format_q  <= wr_format_d;
            done_q       <= done_d;
            err_q        <= err_d;
            wr_chip_en_q <= 1'b1;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_format  = wr_format_q;
    assign wr_chip_en = wr_chip_en_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_params_loader.sv
// Directed bench for params_loader: basic load, bank crossing, illegal
// commands, read backpressure, stalled source with an ignored command, and
// reset in the middle of a load.

module tb_params_loader;

    localparam int DATA_W = 22;
    localparam int ADDR_W = 15;
    localparam int FMT_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_start;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W:0]   cmd_len;
    logic [FMT_W-1:0]  cmd_format;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              rd_busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [FMT_W-1:0]  wr_format;
    logic              wr_chip_en;
    logic              busy;
    logic              done;
    logic              err;

    params_loader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TOTAL_WORDS(31744), .FMT_W(FMT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_start(cmd_start), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_format(cmd_format),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_format(wr_format), .wr_chip_en(wr_chip_en),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic [ADDR_W-1:0] wq_addr[$];
    logic [DATA_W-1:0] wq_data[$];
    logic [FMT_W-1:0]  wq_fmt[$];
    int                wq_cyc[$];

    always @(posedge clk) cyc++;

    // Write-port monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
            wq_fmt.push_back(wr_format);
            wq_cyc.push_back(cyc);
        end
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wq_addr.delete();
        wq_data.delete();
        wq_fmt.delete();
        wq_cyc.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready),   32'h0);
        chk({tag, "_wr_en"},      32'(wr_en),      32'h0);
        chk({tag, "_wr_addr"},    32'(wr_addr),    32'h0);
        chk({tag, "_wr_data"},    32'(wr_data),    32'h0);
        chk({tag, "_wr_format"},  32'(wr_format),  32'h0);
        chk({tag, "_busy"},       32'(busy),       32'h0);
        chk({tag, "_done"},       32'(done),       32'h0);
        chk({tag, "_err"},        32'(err),        32'h0);
        chk({tag, "_wr_chip_en"}, 32'(wr_chip_en), 32'h1);
    endtask

    task automatic send_cmd(input int a, input int l, input int f);
        cmd_start  = 1'b1;
        cmd_addr   = ADDR_W'(a);
        cmd_len    = (ADDR_W + 1)'(l);
        cmd_format = FMT_W'(f);
        tick();
        cmd_start  = 1'b0;
    endtask

    // Presents consecutive words base, base+1, ... until n are accepted.
    task automatic feed(input int n, input int base);
        int k = 0;
        int guard = 0;
        logic acc;
        while (k < n && guard < 200) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(base + k);
            #1;
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
            guard++;
        end
        in_valid = 1'b0;
        chk("feed_accepted", 32'(k), 32'(n));
    endtask

    task automatic chk_writes(input string tag, input int n, input int a0,
                              input int d0, input int f, input bit contiguous);
        chk({tag, "_count"}, 32'(wq_addr.size()), 32'(n));
        for (int k = 0; k < n && k < wq_addr.size(); k++) begin
            chk({tag, "_addr"}, 32'(wq_addr[k]), 32'(a0 + k));
            chk({tag, "_data"}, 32'(wq_data[k]), 32'(d0 + k));
            chk({tag, "_fmt"},  32'(wq_fmt[k]),  32'(f));
            if (contiguous && k > 0)
                chk({tag, "_gap"}, 32'(wq_cyc[k] - wq_cyc[k-1]), 32'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_start = 1'b0; cmd_addr = '0; cmd_len = '0;
        cmd_format = '0; in_valid = 1'b0; in_data = '0; rd_busy = 1'b0;

        // Reset values
        tick(); tick();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick();
        chk_reset_vals("idle");

        // Basic load, cycle exact
        clear_mon();
        send_cmd(0, 4, 2);
        chk("basic_busy", 32'(busy), 32'h1);
        chk("basic_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(i + 1);
            tick();
            chk("basic_wr_en",  32'(wr_en),     32'h1);
            chk("basic_addr",   32'(wr_addr),   32'(i));
            chk("basic_data",   32'(wr_data),   32'(i + 1));
            chk("basic_fmt",    32'(wr_format), 32'h2);
            chk("basic_done",   32'(done),      32'(i == 3));
        end
        chk("basic_busy_done", 32'(busy), 32'h1);
        chk("basic_ready_done", 32'(in_ready), 32'h0);
        // A command during DONE is ignored.
        in_valid = 1'b0;
        send_cmd(7, 1, 0);
        chk("basic_idle_busy", 32'(busy), 32'h0);
        chk("basic_idle_err",  32'(err),  32'h0);
        chk("basic_idle_wr",   32'(wr_en), 32'h0);
        chk("basic_idle_done", 32'(done), 32'h0);
        tick();
        chk("basic_ignored_busy", 32'(busy), 32'h0);
        chk("basic_done_cnt", 32'(done_cnt), 32'd1);
        chk_writes("basic", 4, 0, 1, 2, 1'b1);

        // Bank boundary
        clear_mon();
        send_cmd(15870, 4, 1);
        feed(4, 'h100);
        tick();
        chk_writes("bank", 4, 15870, 'h100, 1, 1'b1);
        chk("bank_done_cnt", 32'(done_cnt), 32'd1);
        chk("bank_err_cnt",  32'(err_cnt),  32'd0);

        // Illegal commands
        clear_mon();
        send_cmd(0, 0, 0);
        chk("ill_len0_err",  32'(err),  32'h1);
        chk("ill_len0_busy", 32'(busy), 32'h0);
        tick();
        chk("ill_len0_err_clr", 32'(err), 32'h0);
        send_cmd(31740, 5, 0);
        chk("ill_over_err",  32'(err),  32'h1);
        chk("ill_over_busy", 32'(busy), 32'h0);
        tick();
        chk("ill_wr_cnt", 32'(wq_addr.size()), 32'd0);
        send_cmd(31740, 4, 3);
        chk("edge_busy", 32'(busy), 32'h1);
        chk("edge_err",  32'(err),  32'h0);
        feed(4, 'h3A0);
        tick();
        chk_writes("edge", 4, 31740, 'h3A0, 3, 1'b1);
        chk("ill_err_cnt",  32'(err_cnt),  32'd2);
        chk("edge_done_cnt", 32'(done_cnt), 32'd1);

        // Backpressure from reads
        clear_mon();
        send_cmd(100, 5, 0);
        begin
            int k = 0;
            logic rbz;
            for (int j = 0; j < 7; j++) begin
                rbz = (j == 1 || j == 2);
                rd_busy  = rbz;
                in_valid = 1'b1;
                in_data  = DATA_W'('h200 + k);
                #1;
                chk("bp_ready", 32'(in_ready), 32'(!rbz));
                @(posedge clk);
                #1;
                chk("bp_wr_en", 32'(wr_en), 32'(!rbz));
                if (!rbz) k++;
                chk("bp_done", 32'(done), 32'(j == 6));
            end
        end
        rd_busy = 1'b0; in_valid = 1'b0;
        tick();
        chk_writes("bp", 5, 100, 'h200, 0, 1'b0);
        chk("bp_done_cnt", 32'(done_cnt), 32'd1);

        // Stalled source with a command issued mid-load
        clear_mon();
        send_cmd(500, 3, 2);
        for (int j = 0; j < 5; j++) begin
            in_valid  = (j % 2 == 0);
            in_data   = DATA_W'('h300 + j / 2);
            cmd_start = (j == 1);
            cmd_addr  = '0;
            cmd_len   = '0;
            tick();
            cmd_start = 1'b0;
            chk("stall_busy",  32'(busy),  32'h1);
            chk("stall_err",   32'(err),   32'h0);
            chk("stall_wr_en", 32'(wr_en), 32'(j % 2 == 0));
        end
        in_valid = 1'b0;
        tick();
        chk_writes("stall", 3, 500, 'h300, 2, 1'b0);
        chk("stall_err_cnt",  32'(err_cnt),  32'd0);
        chk("stall_done_cnt", 32'(done_cnt), 32'd1);

        // Reset in the middle of a load
        clear_mon();
        send_cmd(1000, 6, 3);
        feed(2, 'h400);
        rst_n = 1'b0;
        tick();
        chk_reset_vals("midrst");
        rst_n = 1'b1;
        tick();
        chk("midrst_busy",     32'(busy),     32'h0);
        chk("midrst_done_cnt", 32'(done_cnt), 32'd0);
        chk_writes("midrst", 2, 1000, 'h400, 3, 1'b1);
        clear_mon();
        send_cmd(2000, 2, 1);
        chk("fresh_busy", 32'(busy), 32'h1);
        feed(2, 'h500);
        tick();
        chk_writes("fresh", 2, 2000, 'h500, 1, 1'b1);
        chk("fresh_done_cnt", 32'(done_cnt), 32'd1);
        chk("fresh_idle", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
